// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the RV32 instruction-fetch stage.
// Contents:
//   IF_TO_ID_BUS_WD / Branch_or_Jump_BUS_WD : bus widths toward and from decode
//   OPC_JAL / OPC_JALR / OPC_BRANCH         : control-flow opcodes recognised by predecode
//   fetch_state_e                           : fetch FSM state encoding (2-bit)
//   align_pc()                              : forces a PC onto a word boundary
package if_fetch_stage_pkg;

    localparam int IF_TO_ID_BUS_WD       = 64;
    localparam int Branch_or_Jump_BUS_WD = 34;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_RESP  = 2'b01,
        S_HOLD  = 2'b10,
        S_REDIR = 2'b11
    } fetch_state_e;

    // Instructions are 4-byte aligned; drop the two low address bits.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_ctrl_predecode.sv
// Combinational predecode: flags opcodes that change control flow
// (JAL, JALR, conditional branch). Fetch uses it to stop and wait for
// decode's resolved next PC instead of running ahead.
// Ports:
//   opcode_i        in  7  instruction bits [6:0]
//   is_ctrl_flow_o  out 1  1 when the opcode is JAL, JALR or BRANCH
module if_ctrl_predecode
    import if_fetch_stage_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       is_ctrl_flow_o
);

    // Opcode classification
    always_comb begin
        is_ctrl_flow_o = 1'b0;
        case (opcode_i)
            OPC_JAL, OPC_JALR, OPC_BRANCH: is_ctrl_flow_o = 1'b1;
            default:                       is_ctrl_flow_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of a 5-stage RV32 pipeline.
// Issues one instruction-memory request at a time, registers the response
// together with its PC and hands {Instruction, PC} to decode. After any
// control-flow instruction it waits for decode's resolved next PC.
// Ports:
//   clk, rst (async, active-low)
//   Inst_Req_Valid/Inst_Req_Ready/PC_out : memory request channel
//   Inst_Valid/Inst_Ready/Instruction    : memory response channel
//   IF_to_ID_Valid/ID_Allow_in/IF_to_ID_Bus : bundle toward decode
//   to_IF_Valid/Branch_or_Jump_Bus       : resolved next PC from decode
//   Mem_Feedback                         : 1 when no response is outstanding
//   IF_Fetch_Cnt                         : bundles handed to decode
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                             clk,
    input  logic                             rst,
    output logic                             Inst_Req_Valid,
    input  logic                             Inst_Req_Ready,
    output logic [31:0]                      PC_out,
    input  logic                             Inst_Valid,
    output logic                             Inst_Ready,
    input  logic [31:0]                      Instruction,
    input  logic                             ID_Allow_in,
    output logic                             IF_to_ID_Valid,
    output logic [IF_TO_ID_BUS_WD-1:0]       IF_to_ID_Bus,
    input  logic                             to_IF_Valid,
    input  logic [Branch_or_Jump_BUS_WD-1:0] Branch_or_Jump_Bus,
    output logic                             Mem_Feedback,
    output logic [31:0]                      IF_Fetch_Cnt
);

    fetch_state_e               state_q;
    logic [31:0]                pc_q;
    logic [IF_TO_ID_BUS_WD-1:0] bundle_q;
    logic [31:0]                cnt_q;
    logic                       req_valid_q;
    logic                       inst_ready_q;
    logic                       id_valid_q;
    logic                       mem_fb_q;

    logic [31:0]                pc_inc_d;
    logic [31:0]                redir_pc_d;
    logic                       redir_take_s;
    logic                       hold_is_ctrl_s;

    assign pc_inc_d     = pc_q + 32'd4;
    assign redir_pc_d   = align_pc(Branch_or_Jump_Bus[31:0]);
    // Decode must both have resolved the target and still hold the instruction.
    assign redir_take_s = Branch_or_Jump_Bus[33] & Branch_or_Jump_Bus[32] & to_IF_Valid;

    // Predecode looks at the bundle being held, not at the raw memory bus.
    if_ctrl_predecode u_predecode (
        .opcode_i       (bundle_q[38:32]),
        .is_ctrl_flow_o (hold_is_ctrl_s)
    );

    // Fetch FSM with PC, bundle, counter and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            bundle_q     <= 64'd0;
            cnt_q        <= 32'd0;
            req_valid_q  <= 1'b0;
            inst_ready_q <= 1'b0;
            id_valid_q   <= 1'b0;
            mem_fb_q     <= 1'b1;
        end else begin
            case (state_q)
                S_REQ: begin
                    // Valid is raised on the first edge out of reset and is
                    // never dropped until the memory takes the request.
                    if (req_valid_q && Inst_Req_Ready) begin
                        state_q      <= S_RESP;
                        req_valid_q  <= 1'b0;
                        inst_ready_q <= 1'b1;
                        mem_fb_q     <= 1'b0;
                    end else begin
                        req_valid_q  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (inst_ready_q && Inst_Valid) begin
                        bundle_q     <= {Instruction, pc_q};
                        state_q      <= S_HOLD;
                        inst_ready_q <= 1'b0;
                        mem_fb_q     <= 1'b1;
                        id_valid_q   <= 1'b1;
                    end else begin
                        inst_ready_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (id_valid_q && ID_Allow_in) begin
                        cnt_q      <= cnt_q + 32'd1;
                        id_valid_q <= 1'b0;
                        if (hold_is_ctrl_s) begin
                            state_q     <= S_REDIR;
                        end else begin
                            pc_q        <= pc_inc_d;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end else begin
                        id_valid_q <= 1'b1;
                    end
                end
                S_REDIR: begin
                    if (redir_take_s) begin
                        pc_q        <= redir_pc_d;
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                    end else begin
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_REQ;
                    req_valid_q  <= 1'b0;
                    inst_ready_q <= 1'b0;
                    id_valid_q   <= 1'b0;
                    mem_fb_q     <= 1'b1;
                end
            endcase
        end
    end

    assign Inst_Req_Valid = req_valid_q;
    assign PC_out         = pc_q;
    assign Inst_Ready     = inst_ready_q;
    assign IF_to_ID_Valid = id_valid_q;
    assign IF_to_ID_Bus   = bundle_q;
    assign Mem_Feedback   = mem_fb_q;
    assign IF_Fetch_Cnt   = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage. A reference model walks a
// random program image and predicts the sequence of request addresses and
// {Instruction, PC} bundles; monitors compare each handshake as it happens.
module tb_if_fetch_stage;

    localparam int NB      = 300;
    localparam int MAX_CYC = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready = 1'b0;
    logic [31:0] PC_out;
    logic        Inst_Valid = 1'b0;
    logic        Inst_Ready;
    logic [31:0] Instruction = 32'd0;
    logic        ID_Allow_in = 1'b0;
    logic        IF_to_ID_Valid;
    logic [63:0] IF_to_ID_Bus;
    logic        to_IF_Valid = 1'b0;
    logic [33:0] Branch_or_Jump_Bus = 34'd0;
    logic        Mem_Feedback;
    logic [31:0] IF_Fetch_Cnt;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                (clk),
        .rst                (rst),
        .Inst_Req_Valid     (Inst_Req_Valid),
        .Inst_Req_Ready     (Inst_Req_Ready),
        .PC_out             (PC_out),
        .Inst_Valid         (Inst_Valid),
        .Inst_Ready         (Inst_Ready),
        .Instruction        (Instruction),
        .ID_Allow_in        (ID_Allow_in),
        .IF_to_ID_Valid     (IF_to_ID_Valid),
        .IF_to_ID_Bus       (IF_to_ID_Bus),
        .to_IF_Valid        (to_IF_Valid),
        .Branch_or_Jump_Bus (Branch_or_Jump_Bus),
        .Mem_Feedback       (Mem_Feedback),
        .IF_Fetch_Cnt       (IF_Fetch_Cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_tab [256];
    logic [31:0] tgt_tab [256];
    logic [63:0] exp_bundle_q [$];
    logic [31:0] exp_req_q [$];
    bit          exp_ctrl_arr [NB];
    logic [31:0] exp_tgt_arr [NB];
    int          hs_done = 0;
    bit          mon_en  = 1'b0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return mem_tab[a[9:2]];
    endfunction

    function automatic bit is_ctrl(input logic [31:0] inst);
        logic [6:0] o;
        o = inst[6:0];
        return (o == 7'b1101111) || (o == 7'b1100111) || (o == 7'b1100011);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Protocol and scoreboard monitor, sampled on the falling edge
    bit          p_ok = 1'b0;
    logic        p_rv, p_rr, p_iv, p_al;
    logic [31:0] p_pc;
    logic [63:0] p_bus;
    always @(negedge clk) begin
        if (mon_en) begin
            if (p_ok && p_rv && !p_rr) begin
                check("req_held_valid", {63'd0, Inst_Req_Valid}, 64'd1);
                check("req_held_pc", {32'd0, PC_out}, {32'd0, p_pc});
            end
            if (p_ok && p_iv && !p_al) begin
                check("bundle_held_valid", {63'd0, IF_to_ID_Valid}, 64'd1);
                check("bundle_held_bus", IF_to_ID_Bus, p_bus);
            end
            check("mem_feedback", {63'd0, Mem_Feedback}, {63'd0, !Inst_Ready});
            check("one_phase", {63'd0, (32'(Inst_Req_Valid) + 32'(Inst_Ready) + 32'(IF_to_ID_Valid)) <= 32'd1}, 64'd1);
            if (Inst_Req_Valid && Inst_Req_Ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_request actual=%h expected=none", PC_out);
                end else begin
                    check("req_addr", {32'd0, PC_out}, {32'd0, exp_req_q.pop_front()});
                end
            end
            if (IF_to_ID_Valid && ID_Allow_in) begin
                check("fetch_cnt", {32'd0, IF_Fetch_Cnt}, 64'(hs_done));
                if (exp_bundle_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_bundle actual=%h expected=none", IF_to_ID_Bus);
                end else begin
                    check("bundle", IF_to_ID_Bus, exp_bundle_q.pop_front());
                end
                hs_done++;
            end
            p_ok  = 1'b1;
            p_rv  = Inst_Req_Valid;
            p_rr  = Inst_Req_Ready;
            p_pc  = PC_out;
            p_iv  = IF_to_ID_Valid;
            p_al  = ID_Allow_in;
            p_bus = IF_to_ID_Bus;
        end
    end

    // Reference model, stimulus (memory + decode) and directed reset checks
    initial begin
        logic [31:0] pc, inst, hi, r3, r32, req_a, pend_a, rtgt;
        logic [6:0]  opc;
        bit          req_f, rsp_f, id_f, rd_f, pend, rwait, drove;
        int          lat, rdel, k, cyc, sel, n;

        for (int i = 0; i < 256; i++) begin
            hi = $urandom;
            case ($urandom_range(0, 9))
                0:       opc = 7'b1101111;
                1:       opc = 7'b1100111;
                2:       opc = 7'b1100011;
                3:       opc = 7'b0100011;
                default: opc = 7'b0010011;
            endcase
            mem_tab[i] = {hi[31:7], opc};
            tgt_tab[i] = $urandom_range(0, 1023);
        end
        pc = 32'd0;
        for (int j = 0; j < NB; j++) begin
            inst = imem(pc);
            exp_bundle_q.push_back({inst, pc});
            exp_req_q.push_back(pc);
            exp_ctrl_arr[j] = is_ctrl(inst);
            exp_tgt_arr[j]  = tgt_tab[pc[9:2]];
            if (exp_ctrl_arr[j]) pc = tgt_tab[pc[9:2]] & 32'hFFFF_FFFC;
            else                 pc = pc + 32'd4;
        end

        // Reset state, with memory pretending to be ready and responding
        Inst_Req_Ready = 1'b1;
        Inst_Valid     = 1'b1;
        ID_Allow_in    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", {63'd0, Inst_Req_Valid}, 64'd0);
        check("rst_inst_ready", {63'd0, Inst_Ready}, 64'd0);
        check("rst_id_valid", {63'd0, IF_to_ID_Valid}, 64'd0);
        check("rst_mem_fb", {63'd0, Mem_Feedback}, 64'd1);
        check("rst_pc", {32'd0, PC_out}, 64'd0);
        check("rst_cnt", {32'd0, IF_Fetch_Cnt}, 64'd0);
        check("rst_bus", IF_to_ID_Bus, 64'd0);
        Inst_Valid = 1'b0;

        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        req_f = 0; rsp_f = 0; id_f = 0; rd_f = 0; pend = 0; rwait = 0;
        lat = 0; rdel = 0; k = 0; cyc = 0;
        req_a = 32'd0; pend_a = 32'd0; rtgt = 32'd0;
        while (k < NB && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            if (req_f) begin pend = 1; pend_a = req_a; lat = $urandom_range(0, 2); end
            if (rsp_f) pend = 0;
            if (rd_f)  rwait = 0;
            if (id_f) begin
                if (exp_ctrl_arr[k]) begin
                    rwait = 1; rdel = $urandom_range(0, 4); rtgt = exp_tgt_arr[k];
                end
                k++;
            end
            Inst_Req_Ready = ($urandom_range(0, 3) != 0);
            if (pend && lat == 0) begin
                Inst_Valid = 1'b1; Instruction = imem(pend_a);
            end else if (pend) begin
                lat--; Inst_Valid = 1'b0; Instruction = $urandom;
            end else begin
                Inst_Valid = ($urandom_range(0, 2) == 0); Instruction = $urandom;
            end
            ID_Allow_in = ($urandom_range(0, 2) != 0);
            r3 = $urandom; r32 = $urandom;
            drove = 0;
            if (rwait && rdel == 0) begin
                Branch_or_Jump_Bus = {1'b1, 1'b1, rtgt}; to_IF_Valid = 1'b1; drove = 1;
            end else if (rwait) begin
                rdel--;
                sel = $urandom_range(0, 2);
                Branch_or_Jump_Bus = {sel != 0, sel != 1, r32}; to_IF_Valid = (sel != 2);
            end else begin
                Branch_or_Jump_Bus = {r3[1], r3[0], r32}; to_IF_Valid = r3[2];
            end
            req_f = Inst_Req_Valid && Inst_Req_Ready;
            req_a = PC_out;
            rsp_f = Inst_Ready && Inst_Valid;
            id_f  = IF_to_ID_Valid && ID_Allow_in;
            rd_f  = drove;
        end
        mon_en = 1'b0;
        checks++;
        if (k < NB) begin
            failures++;
            $display("FAIL bundle_budget actual=%0d expected=%0d", k, NB);
        end

        // Reset while a response is pending in S_RESP
        Inst_Valid = 1'b0; Inst_Req_Ready = 1'b1; ID_Allow_in = 1'b1;
        Branch_or_Jump_Bus = {1'b1, 1'b1, 32'h0000_0100}; to_IF_Valid = 1'b1;
        n = 0;
        while (!Inst_Ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("reach_resp", {63'd0, Inst_Ready}, 64'd1);
        Inst_Valid = 1'b1; Instruction = 32'h0000_0013;
        rst = 1'b0;
        #1;
        check("midrst_inst_ready", {63'd0, Inst_Ready}, 64'd0);
        check("midrst_req_valid", {63'd0, Inst_Req_Valid}, 64'd0);
        check("midrst_id_valid", {63'd0, IF_to_ID_Valid}, 64'd0);
        check("midrst_pc", {32'd0, PC_out}, 64'd0);
        check("midrst_cnt", {32'd0, IF_Fetch_Cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("restart_req_valid", {63'd0, Inst_Req_Valid}, 64'd1);
        check("restart_pc", {32'd0, PC_out}, 64'd0);
        check("restart_stale_ignored", {63'd0, IF_to_ID_Valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
